// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a single-port SRAM.
// Ports: clk, rst (async active-low); IF request if_valid/if_addr -> if_ready;
// data request dm_valid/dm_addr/dm_we/dm_wstrb/dm_wdata -> dm_ready;
// read response resp_valid/resp_id/resp_rdata (one cycle after a read grant);
// SRAM side SRAM_WEB/SRAM_BWEB/SRAM_A/SRAM_IN (driven in the grant cycle) and SRAM_OUT.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  input  logic        dm_valid,
  input  logic [15:0] dm_addr,
  input  logic        dm_we,
  input  logic [3:0]  dm_wstrb,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_rdata,
  output logic        SRAM_WEB,
  output logic [31:0] SRAM_BWEB,
  output logic [13:0] SRAM_A,
  output logic [31:0] SRAM_IN,
  input  logic [31:0] SRAM_OUT
);
  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CW-1:0] r_starve;
  logic          r_rd_pend;
  logic          r_rd_id;
  logic [13:0]   r_sram_a;
  logic [31:0]   r_sram_in;
  logic          w_if_pri;
  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic          w_dm_wr;
  logic          w_rd_gnt;
  logic          w_unused;
  // grants are gated by rst so the SRAM port is quiet while reset is held
  assign w_if_pri = if_valid && (r_starve == CW'(STARVE_LIMIT));
  assign w_if_gnt = rst && if_valid && (w_if_pri || !dm_valid);
  assign w_dm_gnt = rst && dm_valid && !w_if_pri;
  // a write with no strobes is still granted but never touches the array
  assign w_dm_wr  = w_dm_gnt && dm_we && (|dm_wstrb);
  assign w_rd_gnt = w_if_gnt || (w_dm_gnt && !dm_we);
  assign w_unused = ^{if_addr[1:0], dm_addr[1:0]};
  assign if_ready   = w_if_gnt;
  assign dm_ready   = w_dm_gnt;
  assign SRAM_WEB   = !w_dm_wr;
  assign SRAM_BWEB  = w_dm_wr ? ~{{8{dm_wstrb[3]}}, {8{dm_wstrb[2]}}, {8{dm_wstrb[1]}}, {8{dm_wstrb[0]}}} : '1;
  assign SRAM_A     = w_if_gnt ? if_addr[15:2] : w_dm_gnt ? dm_addr[15:2] : r_sram_a;
  assign SRAM_IN    = (w_dm_gnt && dm_we) ? dm_wdata : r_sram_in;
  assign resp_valid = r_rd_pend;
  assign resp_id    = r_rd_id;
  assign resp_rdata = r_rd_pend ? SRAM_OUT : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
      r_sram_a  <= '0;
      r_sram_in <= '0;
    end else begin
      r_starve  <= (!if_valid || w_if_gnt) ? '0 : (r_starve == CW'(STARVE_LIMIT)) ? r_starve : r_starve + 1'b1;
      r_rd_pend <= w_rd_gnt;
      r_rd_id   <= w_rd_gnt ? !w_if_gnt : r_rd_id;
      r_sram_a  <= SRAM_A;
      r_sram_in <= SRAM_IN;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles an IF request may be refused before it gains priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_valid  input  1  instruction-fetch read request.
REQ-005 if_addr  input  16  IF byte address.
REQ-006 if_ready  output  1  IF request granted this cycle.
REQ-007 dm_valid  input  1  data-port request.
REQ-008 dm_addr  input  16  data byte address.
REQ-009 dm_we  input  1  1 = write, 0 = read.
REQ-010 dm_wstrb  input  4  byte-write strobes, bit i = byte i.
REQ-011 dm_wdata  input  32  write data.
REQ-012 dm_ready  output  1  data request granted this cycle.
REQ-013 resp_valid  output  1  read data valid.
REQ-014 resp_id  output  1  0 = IF, 1 = data port.
REQ-015 resp_rdata  output  32  read data.
REQ-016 SRAM_WEB  output  1  active-low write enable.
REQ-017 SRAM_BWEB  output  32  active-low bit write enable.
REQ-018 SRAM_A  output  14  word address.
REQ-019 SRAM_IN  output  32  write data.
REQ-020 SRAM_OUT  input  32  read data, valid the cycle after a read access.

Function
REQ-021 At most one grant per cycle; if_ready and dm_ready never both 1.
REQ-022 Default priority: data port over IF.
REQ-023 starve_cnt (3 bits min) increments each cycle if_valid=1 and if_ready=0, clears when if_ready=1 or if_valid=0, saturates at STARVE_LIMIT.
REQ-024 When starve_cnt == STARVE_LIMIT and if_valid=1, IF wins over data port that cycle.
REQ-025 Ready is combinational from valid, priority and starve_cnt; no grant without matching valid.
REQ-026 Granted access drives SRAM in same cycle: SRAM_A = addr[15:2] of winner.
REQ-027 Granted data write: SRAM_WEB=0, SRAM_BWEB byte i bits = ~dm_wstrb[i], SRAM_IN = dm_wdata.
REQ-028 Granted read (IF or data): SRAM_WEB=1, SRAM_BWEB=all 1s.
REQ-029 No grant: SRAM_WEB=1, SRAM_BWEB=all 1s, SRAM_A and SRAM_IN hold last driven value.
REQ-030 Data write with dm_wstrb=0 is granted, drives SRAM_WEB=1, produces no response.
REQ-031 Read latency 1: registered rd_pend/rd_id; cycle after read grant resp_valid=1, resp_id=winner, resp_rdata=SRAM_OUT.
REQ-032 resp_valid=0 in all other cycles; writes produce no response; resp_rdata undefined-free (holds 0 when resp_valid=0).
REQ-033 Back-to-back reads each cycle sustain one response per cycle, order preserved.
REQ-034 dm_addr/if_addr bits [1:0] ignored; no misalignment error.

Reset
REQ-035 rst low asynchronously forces: starve_cnt=0, rd_pend=0, resp_valid=0, resp_id=0, resp_rdata=0, if_ready=0, dm_ready=0, SRAM_WEB=1, SRAM_BWEB=all 1s, SRAM_A=0, SRAM_IN=0.
REQ-036 Read granted in cycle of reset assertion produces no response after reset release.
REQ-037 First grant possible in first clock cycle with rst high.

Verification
REQ-038 IF only: if_valid=1, if_addr=0x0010 -> if_ready=1, SRAM_A=0x0004; next cycle resp_valid=1, resp_id=0, resp_rdata=SRAM_OUT.
REQ-039 Write: dm_valid=1, dm_we=1, dm_addr=0x0104, dm_wstrb=4'b0011, dm_wdata=0xDEADBEEF -> SRAM_WEB=0, SRAM_BWEB=0xFFFF0000, SRAM_A=0x0041, no resp_valid next cycle.
REQ-040 Contention: if_valid and dm_valid held 1 continuously -> dm_ready 4 cycles, IF granted on 5th, data next; pattern repeats.
REQ-041 Alternating reads IF 0x0000 / data 0x0008 each cycle -> responses one per cycle, resp_id sequence matches grant order.
REQ-042 Reset mid-read: read granted, rst low before next edge -> resp_valid stays 0, SRAM_WEB=1, starve_cnt=0.
